flux_scheduler: RTL

- Round-robin burst scheduler for multi-flux HEVC actors: FLUX input FIFOs share one actor and one output FIFO.
- Replaces fixed highest-index priority with fair rotation.
- A granted flux keeps the actor for up to BURST tokens, then the grant rotates.
- Drives per-flux read strobes, the output write strobe and the flux tag that the actor uses to index its per-flux state.

---
 rtl/flux_scheduler.sv | 107 ++++++++++
 1 files changed

// File: rtl/flux_scheduler.sv
// Round-robin burst scheduler: FLUX input FIFOs share one actor and one output FIFO.
// A granted flux keeps the actor for up to BURST tokens, then the grant rotates.
module flux_scheduler #(
    parameter  int FLUX      = 2,
    parameter  int BURST     = 4,
    localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1,
    localparam int CNT_WIDTH = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [FLUX-1:0]      empty,
    input  logic                 full,
    output logic [FLUX-1:0]      read,
    output logic                 write,
    output logic [TAG_WIDTH-1:0] tag,
    output logic                 grant_valid,
    output logic                 burst_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t               state_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [TAG_WIDTH-1:0] ptr_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic                 pick_found;
    logic [TAG_WIDTH-1:0] pick_idx;
    logic [TAG_WIDTH-1:0] ptr_d;
    logic                 xfer;
    logic                 last;

    // First non-empty flux starting at ptr_q; the index wraps by subtraction so a
    // non-power-of-2 FLUX never yields an index >= FLUX.
    always_comb begin
        logic [TAG_WIDTH:0] idx;
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = '0;
        for (int k = 0; k < FLUX; k++) begin
            idx = {1'b0, ptr_q} + (TAG_WIDTH+1)'(k);
            if (idx >= (TAG_WIDTH+1)'(FLUX)) begin
                idx = idx - (TAG_WIDTH+1)'(FLUX);
            end
            if (!pick_found && !empty[idx[TAG_WIDTH-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = idx[TAG_WIDTH-1:0];
            end
        end
    end

    assign ptr_d = (tag_q == TAG_WIDTH'(FLUX-1)) ? '0 : tag_q + 1'b1;
    assign xfer  = (state_q == SERVE) & en & ~empty[tag_q] & ~full;
    assign last  = (cnt_q == CNT_WIDTH'(BURST-1));

    always_comb begin
        read = '0;
        if (xfer) begin
            read[tag_q] = 1'b1;
        end
    end

    assign write       = xfer;
    assign burst_done  = xfer & last;
    assign grant_valid = (state_q == SERVE);
    assign tag         = tag_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tag_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        tag_q   <= pick_idx;
                        cnt_q   <= '0;
                        state_q <= SERVE;
                    end
                end
                SERVE: begin
                    if (xfer && last) begin
                        state_q <= IDLE;
                        ptr_q   <= ptr_d;
                        cnt_q   <= '0;
                    end else if (xfer) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else if (!full && empty[tag_q]) begin
                        // Flux ran dry before its burst ended: hand the actor on.
                        state_q <= IDLE;
                        ptr_q   <= ptr_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
